// File: rtl/bus_master_gen_if.sv
// bus_master_gen_if: command, req/ack bus and response signals of the request master
interface bus_master_gen_if #(parameter int AW = 32, parameter int DW = 32, parameter int CW = 16);
  logic cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic master_req, master_cmd;
  logic [AW-1:0] master_addr;
  logic [DW-1:0] master_wdata;
  logic ack;
  logic [DW-1:0] slave_rdata;
  logic rsp_valid, rsp_we, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic busy;
  logic [CW-1:0] txn_cnt;
  modport master (
    input cmd_valid, cmd_we, cmd_addr, cmd_wdata, ack, slave_rdata,
    output cmd_ready, master_req, master_cmd, master_addr, master_wdata,
    output rsp_valid, rsp_we, rsp_rdata, rsp_err, busy, txn_cnt
  );
  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, ack, slave_rdata,
    input cmd_ready, master_req, master_cmd, master_addr, master_wdata,
    input rsp_valid, rsp_we, rsp_rdata, rsp_err, busy, txn_cnt
  );
endinterface

// File: rtl/bus_master_gen.sv
// bus_master_gen: FIFO-fed req/ack bus master with per-transfer responses and a transfer counter.
// Define MASTER_TIMEOUT_EN to abort transfers left unacknowledged for TIMEOUT req cycles.
module bus_master_gen #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 64,
  parameter int CW = 16
) (
  input logic clk,
  input logic rst,
  bus_master_gen_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state;
  logic [AW+DW:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0] count;
  logic [AW+DW:0] head;
  logic empty, push, pop, done, abort;
`ifdef MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tcnt;
  assign abort = state == REQ && !bus.ack && tcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (rst || pop) tcnt <= '0;
    else if (state == REQ && !bus.ack) tcnt <= tcnt + 1'b1;
`else
  assign abort = 1'b0;
`endif
  assign empty = count == '0;
  assign bus.cmd_ready = count != (PW+1)'(DEPTH);
  assign bus.busy = !empty || bus.master_req;
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign done = state == REQ && (bus.ack || abort);
  assign pop = !empty && (state == IDLE || done);
  assign head = mem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      bus.master_req <= 1'b0;
      bus.master_cmd <= 1'b0;
      bus.master_addr <= '0;
      bus.master_wdata <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_we <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
      bus.txn_cnt <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {bus.cmd_we, bus.cmd_addr, bus.cmd_wdata};
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
      bus.rsp_valid <= done;
      bus.rsp_we <= done && bus.master_cmd;
      bus.rsp_rdata <= (done && bus.ack && !bus.master_cmd) ? bus.slave_rdata : '0;
      bus.rsp_err <= done && !bus.ack;
      if (done) bus.txn_cnt <= bus.txn_cnt + 1'b1;
      if (pop) begin
        state <= REQ;
        bus.master_req <= 1'b1;
        bus.master_cmd <= head[AW+DW];
        bus.master_addr <= head[AW+DW-1:DW];
        bus.master_wdata <= head[AW+DW] ? head[DW-1:0] : '0;
      end else if (done) begin
        state <= IDLE;
        bus.master_req <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_bus_master_gen.sv
// tb_bus_master_gen: directed and randomized checks of bus_master_gen against a queue-based model
module tb_bus_master_gen;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} cmd_t;
  cmd_t q[$];

  bus_master_gen_if #(.AW(32), .DW(32), .CW(4)) bus ();
  bus_master_gen #(.AW(32), .DW(32), .DEPTH(DEPTH), .TIMEOUT(8), .CW(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_fields;
    chk("req_high", bus.master_req, 1);
    chk("cmd", bus.master_cmd, q[0].we);
    chk("addr", bus.master_addr, q[0].addr);
    chk("wdata", bus.master_wdata, q[0].we ? q[0].wdata : 32'h0);
  endtask

  task automatic chk_rsp(input logic [31:0] rd);
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("rsp_we", bus.rsp_we, q[0].we);
    chk("rsp_rdata", bus.rsp_rdata, q[0].we ? 32'h0 : rd);
    chk("rsp_err", bus.rsp_err, 0);
    void'(q.pop_front());
    exp_cnt++;
    chk("txn_cnt", bus.txn_cnt, 64'(exp_cnt % 16));
  endtask

  task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cmd_valid = 1'b1;
    bus.cmd_we = we;
    bus.cmd_addr = addr;
    bus.cmd_wdata = wdata;
    tick;
    bus.cmd_valid = 1'b0;
    q.push_back('{we, addr, wdata});
  endtask

  task automatic wait_req;
    int n = 0;
    while (!bus.master_req && n < 4) begin
      tick;
      n++;
    end
    chk("req_rise", bus.master_req, 1);
  endtask

  // Hold ack low for d req cycles, then ack in the next one.
  task automatic serve(input int d, input logic [31:0] rd);
    wait_req;
    for (int i = 0; i < d; i++) begin
      chk_fields;
      chk("no_rsp", bus.rsp_valid, 0);
      tick;
    end
    chk_fields;
    bus.ack = 1'b1;
    bus.slave_rdata = rd;
    tick;
    bus.ack = 1'b0;
    bus.slave_rdata = $urandom;
    chk_rsp(rd);
    if (q.size() == 0) begin
      chk("req_drop", bus.master_req, 0);
      chk("idle_busy", bus.busy, 0);
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    q.delete();
    exp_cnt = 0;
    chk("rst_req", bus.master_req, 0);
    chk("rst_cmd", bus.master_cmd, 0);
    chk("rst_addr", bus.master_addr, 0);
    chk("rst_wdata", bus.master_wdata, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_we", bus.rsp_we, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_txn", bus.txn_cnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.cmd_ready, 1);
  endtask

  initial begin
    logic [31:0] rd;
    int n;
    bus.cmd_valid = 1'b0;
    bus.cmd_we = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_wdata = '0;
    bus.ack = 1'b0;
    bus.slave_rdata = '0;
    tick;
    do_reset;

    push(1'b1, 32'h10, 32'hDEADBEEF);
    chk("req_latency", bus.master_req, 0);
    serve(2, $urandom);
    push(1'b0, 32'h20, $urandom);
    serve(0, 32'h12345678);

    for (int i = 0; i < DEPTH + 1; i++) begin
      push(1'($urandom), $urandom, $urandom);
      chk("fill_ready", bus.cmd_ready, i < DEPTH);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = 32'hBAD;
    tick;
    bus.cmd_valid = 1'b0;
    chk("full_ready", bus.cmd_ready, 0);
    bus.ack = 1'b1;
    while (q.size() > 0) begin
      chk_fields;
      rd = $urandom;
      bus.slave_rdata = rd;
      tick;
      chk_rsp(rd);
      chk("drain_ready", bus.cmd_ready, 1);
      chk("b2b_req", bus.master_req, q.size() > 0);
    end
    bus.ack = 1'b0;
    chk("b2b_busy", bus.busy, 0);
    chk("b2b_total", bus.txn_cnt, 7);

    for (int i = 0; i < 3; i++) push(1'($urandom), $urandom, $urandom);
    chk("mid_req", bus.master_req, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    q.delete();
    exp_cnt = 0;
    chk("mr_req", bus.master_req, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_txn", bus.txn_cnt, 0);
    chk("mr_rsp", bus.rsp_valid, 0);
    tick;
    chk("mr_flushed", bus.master_req, 0);
    chk("mr_rsp2", bus.rsp_valid, 0);
    push(1'b0, 32'h44, 32'h0);
    serve(1, 32'hCAFEF00D);

`ifdef MASTER_TIMEOUT_EN
    push(1'b1, 32'h80, 32'h55AA);
    wait_req;
    n = 0;
    while (bus.master_req && n < 20) begin
      tick;
      n++;
    end
    chk("to_len", 64'(n), 8);
    chk("to_valid", bus.rsp_valid, 1);
    chk("to_err", bus.rsp_err, 1);
    chk("to_rdata", bus.rsp_rdata, 0);
    chk("to_we", bus.rsp_we, 1);
    void'(q.pop_front());
    exp_cnt++;
    chk("to_txn", bus.txn_cnt, 64'(exp_cnt));
    push(1'b0, 32'h84, 32'h0);
    serve(7, 32'h0BADCAFE);
`endif

    do_reset;
    for (int i = 0; i < 17; i++) begin
      push(1'($urandom), $urandom, $urandom);
      serve(int'($urandom_range(0, 3)), $urandom);
    end
    chk("wrap_txn", bus.txn_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
